tft_pic_move: RTL and testbench

TFT_PIC_MOVE -- requirements
Module: tft_pic_move

---
 rtl/tft_pic_move.sv | 122 ++++++++++++
 tb/tb_tft_pic_move.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tft_pic_move.sv
// Colour-bar background with a bouncing ROM sprite for a TFT raster; pix_data lags pix_x/pix_y by one clock.
// Optional colour-key transparency: define TFT_PIC_TRANSPARENT_EN.
module tft_pic_move #(
  parameter int          H_VALID   = 480,
  parameter int          V_VALID   = 272,
  parameter int          IMAGE_W   = 100,
  parameter int          IMAGE_H   = 100,
  parameter int          STEP_X    = 2,
  parameter int          STEP_Y    = 1,
  parameter int          MOVE_DIV  = 1,
  parameter int          ADDR_W    = 14,
  parameter logic [15:0] KEY_COLOR = 16'h0000
) (
  input  logic              tft_clk,
  input  logic              sys_rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              move_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [15:0]       rom_data,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic [15:0]       pix_data
);
  localparam logic [10:0] HV    = 11'(H_VALID);
  localparam logic [10:0] VV    = 11'(V_VALID);
  localparam logic [10:0] IW    = 11'(IMAGE_W);
  localparam logic [10:0] IH    = 11'(IMAGE_H);
  localparam logic [10:0] SX    = 11'(STEP_X);
  localparam logic [10:0] SY    = 11'(STEP_Y);
  localparam logic [10:0] X_MAX = 11'(H_VALID - IMAGE_W);
  localparam logic [10:0] Y_MAX = 11'(V_VALID - IMAGE_H);
  localparam logic [10:0] BAR_W = 11'(H_VALID / 10);
  localparam logic [9:0]  X_C   = 10'((H_VALID - IMAGE_W) / 2);
  localparam logic [9:0]  Y_C   = 10'((V_VALID - IMAGE_H) / 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMAGE_W * IMAGE_H - 1);
  localparam logic [7:0]  FRM_LAST = 8'(MOVE_DIV - 1);
  // index 0 is the leftmost bar
  localparam logic [9:0][15:0] BAR_COLOR = {
    16'hD69A, 16'hFFFF, 16'h0000, 16'hF81F, 16'h001F,
    16'h07FF, 16'h07E0, 16'hFFE0, 16'hFC00, 16'hF800};

  typedef enum logic {INC, DEC} dir_t;

  logic [10:0] x11, y11, px11, py11;
  logic [3:0]  bar_idx;
  logic [15:0] bg_next, bg;
  logic        image_valid, frame_end, move_evt;
  logic [7:0]  frm_cnt;
  dir_t        x_st, y_st;

  assign x11  = {1'b0, pix_x};
  assign y11  = {1'b0, pix_y};
  assign px11 = {1'b0, pos_x};
  assign py11 = {1'b0, pos_y};

  assign rom_rd_en = (x11 >= px11) && (x11 < px11 + IW) &&
                     (y11 >= py11) && (y11 < py11 + IH);
  assign frame_end = (x11 == HV - 11'd1) && (y11 == VV - 11'd1);
  assign move_evt  = frame_end && move_en && (frm_cnt == FRM_LAST);

  always_comb begin
    bar_idx = 4'd0;
    for (int k = 1; k < 10; k++)
      if (x11 >= 11'(k) * BAR_W) bar_idx = 4'(k);
    bg_next = (x11 >= HV) ? 16'h0000 : BAR_COLOR[bar_idx];
  end

  always_ff @(posedge tft_clk) begin
    if (sys_rst) begin
      bg          <= 16'h0000;
      image_valid <= 1'b0;
    end else begin
      bg          <= bg_next;
      image_valid <= rom_rd_en;
    end
  end

  // frame_end clear wins over the window increment
  always_ff @(posedge tft_clk) begin
    if (sys_rst || frame_end)   rom_addr <= '0;
    else if (rom_rd_en)         rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
  end

  always_ff @(posedge tft_clk) begin
    if (sys_rst)                   frm_cnt <= 8'd0;
    else if (frame_end && move_en) frm_cnt <= (frm_cnt == FRM_LAST) ? 8'd0 : frm_cnt + 8'd1;
  end

  // position only moves on the last active pixel, so a frame never sees two positions
  always_ff @(posedge tft_clk) begin
    if (sys_rst) begin
      pos_x <= X_C;
      pos_y <= Y_C;
      x_st  <= INC;
      y_st  <= INC;
    end else if (move_evt) begin
      case (x_st)
        INC: if (px11 + SX >= X_MAX) begin pos_x <= X_MAX[9:0]; x_st <= DEC; end
             else pos_x <= pos_x + SX[9:0];
        DEC: if (px11 <= SX) begin pos_x <= 10'd0; x_st <= INC; end
             else pos_x <= pos_x - SX[9:0];
      endcase
      case (y_st)
        INC: if (py11 + SY >= Y_MAX) begin pos_y <= Y_MAX[9:0]; y_st <= DEC; end
             else pos_y <= pos_y + SY[9:0];
        DEC: if (py11 <= SY) begin pos_y <= 10'd0; y_st <= INC; end
             else pos_y <= pos_y - SY[9:0];
      endcase
    end
  end

`ifdef TFT_PIC_TRANSPARENT_EN
  assign pix_data = (image_valid && rom_data != KEY_COLOR) ? rom_data : bg;
`else
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
  assign pix_data   = image_valid ? rom_data : bg;
`endif

endmodule

// File: tb/tb_tft_pic_move.sv
// Self-checking bench for tft_pic_move on a shrunken 100x40 raster with a 20x10 sprite.
// Pixel expectations are queued when a coordinate is driven and checked one clock later.
module tb_tft_pic_move;
  localparam int H = 100, V = 40, IW = 20, IH = 10, SX = 2, SY = 1, DIV = 3, AW = 8;

  logic          tft_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [9:0]    pix_x = 10'(H), pix_y = 10'(V);
  logic          move_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd_en;
  logic [15:0]   rom_data = 16'h0000;
  logic [9:0]    pos_x, pos_y;
  logic [15:0]   pix_data;

  tft_pic_move #(.H_VALID(H), .V_VALID(V), .IMAGE_W(IW), .IMAGE_H(IH), .STEP_X(SX),
                 .STEP_Y(SY), .MOVE_DIV(DIV), .ADDR_W(AW), .KEY_COLOR(16'h0000)) dut (
    .tft_clk(tft_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y), .move_en(move_en),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
    .pos_x(pos_x), .pos_y(pos_y), .pix_data(pix_data));

  always #5 tft_clk = ~tft_clk;

  // ROM returns its own address, one clock after the request
  always @(posedge tft_clk) if (rom_rd_en) rom_data <= 16'(rom_addr);

  int rd_cnt = 0;
  always @(posedge tft_clk) if (rom_rd_en) rd_cnt++;

  typedef struct { logic chk; logic [15:0] exp; } sb_t;
  typedef struct { int x; int y; logic [15:0] exp; } vec_t;
  sb_t  q[$];
  vec_t vt[18];

  int n_chk = 0, n_fail = 0;
  int mx, my, mfrm;
  bit mxd, myd;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] bar(int x);
    if (x >= H) return 16'h0000;
    case (x / 10)
      0: return 16'hF800;  1: return 16'hFC00;  2: return 16'hFFE0;  3: return 16'h07E0;
      4: return 16'h07FF;  5: return 16'h001F;  6: return 16'hF81F;  7: return 16'h0000;
      8: return 16'hFFFF;  default: return 16'hD69A;
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(int x, int y);
    logic [15:0] d;
    if (x >= mx && x < mx + IW && y >= my && y < my + IH) begin
      d = 16'((y - my) * IW + (x - mx));
`ifdef TFT_PIC_TRANSPARENT_EN
      if (d == 16'h0000) return bar(x);
`endif
      return d;
    end
    return bar(x);
  endfunction

  task automatic model_reset();
    mx = (H - IW) / 2; my = (V - IH) / 2; mfrm = 0; mxd = 0; myd = 0;
  endtask

  task automatic model_frame_end();
    if (!move_en) return;
    if (mfrm != DIV - 1) begin mfrm++; return; end
    mfrm = 0;
    if (!mxd) begin if (mx + SX >= H - IW) begin mx = H - IW; mxd = 1; end else mx += SX; end
    else      begin if (mx <= SX) begin mx = 0; mxd = 0; end else mx -= SX; end
    if (!myd) begin if (my + SY >= V - IH) begin my = V - IH; myd = 1; end else my += SY; end
    else      begin if (my <= SY) begin my = 0; myd = 0; end else my -= SY; end
  endtask

  // one pixel clock: check the previous pixel, drive the next, queue its expectation
  task automatic cyc(int x, int y, logic chk, logic [15:0] exp);
    sb_t e;
    @(negedge tft_clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) check("pix_data", int'(pix_data), int'(e.exp));
    end
    pix_x = 10'(x);
    pix_y = 10'(y);
    e.chk = chk;
    e.exp = exp;
    q.push_back(e);
    if (!sys_rst && x == H - 1 && y == V - 1) model_frame_end();
  endtask

  task automatic check_pos(string nm);
    check({nm, " pos_x"}, int'(pos_x), mx);
    check({nm, " pos_y"}, int'(pos_y), my);
  endtask

  task automatic adv_frame();
    cyc(H - 1, V - 1, 1'b0, 16'h0);
    cyc(H, V, 1'b0, 16'h0);
    check_pos("frame");
  endtask

  task automatic scan(string nm);
    rd_cnt = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) cyc(x, y, 1'b1, exp_pix(x, y));
    cyc(H, V, 1'b0, 16'h0);
    check({nm, " rd_en cycles"}, rd_cnt, IW * IH);
    check({nm, " rom_addr end"}, int'(rom_addr), 0);
    check_pos(nm);
  endtask

  initial begin
    vt[0]  = '{0, 0, 16'hF800};   vt[1]  = '{9, 0, 16'hF800};   vt[2]  = '{10, 0, 16'hFC00};
    vt[3]  = '{25, 1, 16'hFFE0};  vt[4]  = '{35, 2, 16'h07E0};  vt[5]  = '{45, 3, 16'h07FF};
    vt[6]  = '{55, 4, 16'h001F};  vt[7]  = '{65, 5, 16'hF81F};  vt[8]  = '{75, 6, 16'h0000};
    vt[9]  = '{85, 7, 16'hFFFF};  vt[10] = '{99, 8, 16'hD69A};  vt[11] = '{100, 0, 16'h0000};
    vt[12] = '{500, 3, 16'h0000}; vt[13] = '{39, 15, 16'h07E0}; vt[14] = '{60, 15, 16'hF81F};
    vt[15] = '{40, 25, 16'h07FF};
`ifdef TFT_PIC_TRANSPARENT_EN
    vt[16] = '{40, 15, 16'h07FF};
`else
    vt[16] = '{40, 15, 16'h0000};
`endif
    vt[17] = '{41, 15, 16'h0001};

    // reset state
    model_reset();
    cyc(H, V, 1'b0, 16'h0);
    cyc(H, V, 1'b0, 16'h0);
    check("reset pos_x", int'(pos_x), 40);
    check("reset pos_y", int'(pos_y), 15);
    check("reset rom_addr", int'(rom_addr), 0);
    check("reset pix_data", int'(pix_data), 0);
    check("reset rd_en", int'(rom_rd_en), 0);
    sys_rst = 1'b0;

    // background bars, blanking and window edges
    foreach (vt[i]) cyc(vt[i].x, vt[i].y, 1'b1, vt[i].exp);
    cyc(H, V, 1'b0, 16'h0);
    cyc(H - 1, V - 1, 1'b0, 16'h0);
    cyc(H, V, 1'b0, 16'h0);
    check("frame_end clears rom_addr", int'(rom_addr), 0);

    scan("centre");

    // bounce: 20 moves reach the right limit, then X runs backward
    move_en = 1'b1;
    for (int f = 0; f < 66; f++) begin
      adv_frame();
      if (f == 59) check("x at right limit", int'(pos_x), 80);
    end
    check("x after reversal", int'(pos_x), 76);
    check("y after reversal", int'(pos_y), 23);

    // frozen frames neither move nor advance the divider
    move_en = 1'b0;
    for (int f = 0; f < 5; f++) adv_frame();
    check("frozen pos_x", int'(pos_x), 76);
    move_en = 1'b1;
    adv_frame();
    adv_frame();
    check("divider held x", int'(pos_x), 76);
    adv_frame();
    check("third frame x", int'(pos_x), 74);
    check("third frame y", int'(pos_y), 22);
    move_en = 1'b0;

    scan("moved");

    // reset inside the sprite window mid-frame
    for (int y = 0; y < 26; y++)
      for (int x = 0; x < H; x++)
        if (y < 25 || x < 80) cyc(x, y, 1'b1, exp_pix(x, y));
    cyc(80, 25, 1'b0, 16'h0);
    sys_rst = 1'b1;
    cyc(H, V, 1'b0, 16'h0);
    sys_rst = 1'b0;
    model_reset();
    check("mid reset pos_x", int'(pos_x), 40);
    check("mid reset pos_y", int'(pos_y), 15);
    check("mid reset rom_addr", int'(rom_addr), 0);
    check("mid reset pix_data", int'(pix_data), 0);

    scan("after reset");
    cyc(H, V, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
